// File: rtl/ciphertext_collector.sv
// Rebuilds MSB-first serial ciphertext words from a data/flag pair and checks frame length.
// Word and error pulses update on the edge sampling flag low; one-deep output buffer, overrun drops new word.
module ciphertext_collector #(
    parameter int MSG_SIZE = 64,
    parameter int CNT_W    = $clog2(MSG_SIZE) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                iData_in,
    input  logic                iData_flag,
    input  logic                iReady,
    output logic [MSG_SIZE-1:0] oData,
    output logic                oValid,
    output logic [CNT_W-1:0]    oBit_counter,
    output logic                oErr_short,
    output logic                oErr_long,
    output logic                oErr_overrun,
    output logic [7:0]          oFrame_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        LONG = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(MSG_SIZE);

    state_t              state;
    state_t              state_nxt;
    logic [MSG_SIZE-1:0] shreg;
    logic [MSG_SIZE-1:0] shreg_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                good_frame;
    logic                short_nxt;
    logic                long_nxt;
    logic                commit;
    logic                overrun_nxt;
    logic                valid_nxt;

    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        cnt_nxt    = oBit_counter;
        good_frame = 1'b0;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (iData_flag) begin
                    // Clear stale bits so a new frame never inherits the previous word.
                    shreg_nxt = {{(MSG_SIZE-1){1'b0}}, iData_in};
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (iData_flag) begin
                    if (oBit_counter < FULL) begin
                        shreg_nxt = {shreg[MSG_SIZE-2:0], iData_in};
                        cnt_nxt   = oBit_counter + CNT_W'(1);
                    end else begin
                        state_nxt = LONG;
                    end
                end else begin
                    if (oBit_counter == FULL) begin
                        good_frame = 1'b1;
                    end else begin
                        short_nxt = 1'b1;
                    end
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            LONG: begin
                if (!iData_flag) begin
                    long_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // An accept on the commit edge frees the buffer in time for the new word.
    assign commit      = good_frame & (~oValid | iReady);
    assign overrun_nxt = good_frame & ~commit;
    assign valid_nxt   = commit | (oValid & ~iReady);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            oBit_counter <= '0;
            oData        <= '0;
            oValid       <= 1'b0;
            oErr_short   <= 1'b0;
            oErr_long    <= 1'b0;
            oErr_overrun <= 1'b0;
            oFrame_count <= 8'd0;
        end else if (ena) begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            oBit_counter <= cnt_nxt;
            oValid       <= valid_nxt;
            oErr_short   <= short_nxt;
            oErr_long    <= long_nxt;
            oErr_overrun <= overrun_nxt;
            if (commit) begin
                oData        <= shreg;
                oFrame_count <= oFrame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ciphertext_collector.sv
// Directed bench for ciphertext_collector: good/short/long frames, backpressure, reset, enable, wrap.
module tb_ciphertext_collector;

    localparam int MSG_SIZE = 64;
    localparam int CNT_W    = 7;

    logic                clk = 1'b0;
    logic                rst;
    logic                ena;
    logic                iData_in;
    logic                iData_flag;
    logic                iReady;
    logic [MSG_SIZE-1:0] oData;
    logic                oValid;
    logic [CNT_W-1:0]    oBit_counter;
    logic                oErr_short;
    logic                oErr_long;
    logic                oErr_overrun;
    logic [7:0]          oFrame_count;

    int checks = 0;
    int errors = 0;

    ciphertext_collector #(.MSG_SIZE(MSG_SIZE), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .iData_in    (iData_in),
        .iData_flag  (iData_flag),
        .iReady      (iReady),
        .oData       (oData),
        .oValid      (oValid),
        .oBit_counter(oBit_counter),
        .oErr_short  (oErr_short),
        .oErr_long   (oErr_long),
        .oErr_overrun(oErr_overrun),
        .oFrame_count(oFrame_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive bit positions [first, last) of w, MSB first; positions past 63 send 0.
    task automatic send_bits(input logic [63:0] w, input int first, input int last);
        for (int i = first; i < last; i++) begin
            iData_flag = 1'b1;
            iData_in   = (i < 64) ? w[63-i] : 1'b0;
            tick();
        end
    endtask

    task automatic end_frame();
        iData_flag = 1'b0;
        iData_in   = 1'b0;
        tick();
    endtask

    task automatic chk_errs(input string tag, input logic s, input logic l, input logic o);
        chk({tag, "_short"}, {63'd0, oErr_short}, {63'd0, s});
        chk({tag, "_long"}, {63'd0, oErr_long}, {63'd0, l});
        chk({tag, "_overrun"}, {63'd0, oErr_overrun}, {63'd0, o});
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; iData_in = 1'b0; iData_flag = 1'b0; iReady = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_data", oData, 64'd0);
        chk("rst_valid", {63'd0, oValid}, 64'd0);
        chk("rst_cnt", {57'd0, oBit_counter}, 64'd0);
        chk("rst_fc", {56'd0, oFrame_count}, 64'd0);
        chk_errs("rst", 1'b0, 1'b0, 1'b0);

        // Good frame
        iReady = 1'b1;
        send_bits(64'hDEADBEEF_CAFEF00D, 0, 64);
        chk("good_cnt64", {57'd0, oBit_counter}, 64'd64);
        chk("good_valid_pre", {63'd0, oValid}, 64'd0);
        end_frame();
        chk("good_data", oData, 64'hDEADBEEF_CAFEF00D);
        chk("good_valid", {63'd0, oValid}, 64'd1);
        chk("good_fc", {56'd0, oFrame_count}, 64'd1);
        chk("good_cnt0", {57'd0, oBit_counter}, 64'd0);
        chk_errs("good", 1'b0, 1'b0, 1'b0);
        tick();
        chk("good_valid_drop", {63'd0, oValid}, 64'd0);

        // Short frame
        send_bits(64'h1234_5678_9ABC_DEF0, 0, 40);
        chk("short_cnt40", {57'd0, oBit_counter}, 64'd40);
        end_frame();
        chk_errs("short", 1'b1, 1'b0, 1'b0);
        chk("short_valid", {63'd0, oValid}, 64'd0);
        chk("short_fc", {56'd0, oFrame_count}, 64'd1);
        tick();
        chk("short_pulse_end", {63'd0, oErr_short}, 64'd0);

        // Long frame
        send_bits(64'hFFFF_FFFF_FFFF_FFFF, 0, 65);
        chk("long_cnt_b65", {57'd0, oBit_counter}, 64'd64);
        send_bits(64'hFFFF_FFFF_FFFF_FFFF, 65, 70);
        chk("long_cnt_b70", {57'd0, oBit_counter}, 64'd64);
        chk_errs("long_mid", 1'b0, 1'b0, 1'b0);
        end_frame();
        chk_errs("long", 1'b0, 1'b1, 1'b0);
        chk("long_valid", {63'd0, oValid}, 64'd0);
        chk("long_fc", {56'd0, oFrame_count}, 64'd1);
        tick();
        chk("long_pulse_end", {63'd0, oErr_long}, 64'd0);

        // Backpressure and overrun
        iReady = 1'b0;
        send_bits(64'h1, 0, 64);
        end_frame();
        chk("ovr_a_data", oData, 64'h1);
        chk("ovr_a_valid", {63'd0, oValid}, 64'd1);
        chk("ovr_a_fc", {56'd0, oFrame_count}, 64'd2);
        send_bits(64'h2, 0, 64);
        end_frame();
        chk("ovr_b_data", oData, 64'h1);
        chk("ovr_b_valid", {63'd0, oValid}, 64'd1);
        chk("ovr_b_fc", {56'd0, oFrame_count}, 64'd2);
        chk_errs("ovr_b", 1'b0, 1'b0, 1'b1);
        iReady = 1'b1;
        tick();
        chk("ovr_drain_valid", {63'd0, oValid}, 64'd0);
        chk("ovr_pulse_end", {63'd0, oErr_overrun}, 64'd0);

        // Simultaneous commit and accept
        iReady = 1'b0;
        send_bits(64'hA, 0, 64);
        end_frame();
        chk("sim_a_data", oData, 64'hA);
        send_bits(64'hB, 0, 64);
        chk("sim_valid_hold", {63'd0, oValid}, 64'd1);
        iReady = 1'b1;
        end_frame();
        chk("sim_b_data", oData, 64'hB);
        chk("sim_b_valid", {63'd0, oValid}, 64'd1);
        chk("sim_b_fc", {56'd0, oFrame_count}, 64'd4);
        chk_errs("sim_b", 1'b0, 1'b0, 1'b0);
        tick();
        chk("sim_drain_valid", {63'd0, oValid}, 64'd0);

        // Reset mid-frame
        iReady = 1'b0;
        send_bits(64'hFFFF_0000_FFFF_0000, 0, 30);
        chk("rmid_cnt30", {57'd0, oBit_counter}, 64'd30);
        rst = 1'b1;
        iData_flag = 1'b0;
        tick();
        rst = 1'b0;
        chk("rmid_data", oData, 64'd0);
        chk("rmid_cnt", {57'd0, oBit_counter}, 64'd0);
        chk("rmid_fc", {56'd0, oFrame_count}, 64'd0);
        chk("rmid_valid", {63'd0, oValid}, 64'd0);
        chk_errs("rmid", 1'b0, 1'b0, 1'b0);
        iReady = 1'b1;
        send_bits(64'h0123_4567_89AB_CDEF, 0, 64);
        end_frame();
        chk("rpost_data", oData, 64'h0123_4567_89AB_CDEF);
        chk("rpost_fc", {56'd0, oFrame_count}, 64'd1);
        chk_errs("rpost", 1'b0, 1'b0, 1'b0);

        // Enable freeze mid-frame
        send_bits(64'h5A5A_C3C3_0F0F_9669, 0, 20);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            iData_flag = 1'b1;
            iData_in   = i[0];
            tick();
        end
        chk("ena_cnt_frozen", {57'd0, oBit_counter}, 64'd20);
        ena = 1'b1;
        send_bits(64'h5A5A_C3C3_0F0F_9669, 20, 64);
        end_frame();
        chk("ena_data", oData, 64'h5A5A_C3C3_0F0F_9669);
        chk("ena_fc", {56'd0, oFrame_count}, 64'd2);
        chk_errs("ena", 1'b0, 1'b0, 1'b0);

        // Frame counter wrap
        for (int f = 0; f < 254; f++) begin
            send_bits(64'(f), 0, 64);
            end_frame();
            if (f == 252) chk("wrap_fc255", {56'd0, oFrame_count}, 64'd255);
        end
        chk("wrap_fc0", {56'd0, oFrame_count}, 64'd0);
        chk("wrap_data", oData, 64'd253);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ciphertext_collector.md
# ciphertext_collector

Receive-side stage that sits directly downstream of the ciphertext serializer. It samples the serializer's data/flag pair (the `uo_out[0]` / `uo_out[1]` lines), rebuilds the MSG_SIZE-bit ciphertext word and checks the frame length. It hands each good word to a consumer over a one-deep valid/ready buffer. It is used on the host/FPGA side of the design and in the top-level loopback bench.

## Interface
Parameters:
- MSG_SIZE, 64, ciphertext word width in bits (≥ 2).
- CNT_W, $clog2(MSG_SIZE)+1, bit-counter width.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- ena  in  1  enable; when low, every register holds its value (rst still wins).
- iData_in  in  1  serial ciphertext bit, MSB first.
- iData_flag  in  1  frame qualifier; high while bits are valid.
- iReady  in  1  consumer accepts oData when oValid & iReady.
- oData  out  MSG_SIZE  last good ciphertext word; stable while oValid is high.
- oValid  out  1  word available.
- oBit_counter  out  CNT_W  bits received in the current frame; saturates at MSG_SIZE.
- oErr_short  out  1  one-cycle pulse: frame ended with fewer than MSG_SIZE bits.
- oErr_long  out  1  one-cycle pulse: frame carried more than MSG_SIZE bits.
- oErr_overrun  out  1  one-cycle pulse: good frame dropped because the buffer was full.
- oFrame_count  out  8  count of good frames, wraps 255 → 0.

## Operation
- Reset values: oData = 0, oValid = 0, oBit_counter = 0, all oErr_* = 0, oFrame_count = 0, FSM = IDLE, shift register = 0.
- FSM states: IDLE, RECV, LONG.
- **IDLE**
  - When flag = 1: shift in iData_in, set counter to 1, go to RECV.
- **RECV**
  - Flag = 1 and counter < MSG_SIZE: shift left, insert iData_in at the LSB, counter +1.
  - Flag = 1 and counter = MSG_SIZE: the bit is discarded and the FSM goes to LONG.
  - Flag = 0 and counter = MSG_SIZE: good frame, go to IDLE.
  - Flag = 0 and counter < MSG_SIZE: pulse oErr_short, go to IDLE.
- **LONG**
  - While flag = 1: stay in LONG and discard bits.
  - When flag = 0: pulse oErr_long, go to IDLE. No word is delivered.
- **Good frame commit**
  - Buffer empty, or iReady high in the same cycle: load oData, set oValid, increment oFrame_count.
  - Otherwise: pulse oErr_overrun, keep the old oData/oValid, leave the count unchanged.
- oBit_counter returns to 0 on the cycle the FSM returns to IDLE.
- **Handshake**
  - oValid falls on the edge after oValid & iReady, unless a new commit happens on that same edge.
  - iReady with oValid = 0 has no effect.
- A flag pulse of exactly one cycle is a 1-bit frame. It is short unless MSG_SIZE = 1, which is not supported.
- Back-to-back frames need at least one flag-low cycle between them. That low cycle is the end-of-frame sample.

## Timing
- One bit is sampled per enabled clock edge while the flag is high. There is no oversampling.
- Commit latency: oValid/oData update on the edge that samples the first flag = 0. They are visible one cycle after the last data bit was sampled.
- Error pulses assert on that same edge and last exactly one cycle, unless ena drops. If ena drops, the pulse holds until the next enabled edge.
- Simultaneous commit and accept: the old word is consumed, the new word is loaded, and oValid stays high. No overrun is flagged.
- Reset mid-frame: the partial frame is discarded, outputs return to reset values, and no error pulse is generated.
- Flag held low indefinitely in IDLE: no activity.

## Test plan
- Good frame: send 0xDEADBEEF_CAFEF00D MSB first over 64 flag-high cycles, iReady = 1. Expect:
  - oData = 0xDEADBEEF_CAFEF00D.
  - oValid high for one cycle, one cycle after the last bit.
  - oFrame_count = 1, no error pulses.
- Short/long frames:
  - A 40-bit frame gives an oErr_short pulse, oValid stays 0, count unchanged.
  - A 70-bit frame gives an oErr_long pulse after the flag falls, oValid stays 0.
  - oBit_counter reads 64 throughout bits 65–70 of the long frame.
- Backpressure/overrun: iReady = 0, send frames A = 0x1 then B = 0x2.
  - Expect oData = 0x1 held, an oErr_overrun pulse at B's commit, count = 1.
  - Raising iReady then drops oValid.
- Simultaneous accept: hold word A with iReady low, then raise iReady exactly on B's commit edge. Expect oData = B, oValid continuously high, count = 2, no overrun.
- Reset/ena:
  - Assert rst after 30 bits: all outputs read 0 on the next edge, and the following 64-bit frame decodes correctly.
  - Drop ena for 5 cycles mid-frame with the flag held high: counter frozen, word still correct after ena returns.
- Wrap: 256 good frames take oFrame_count to 0.
